priority_arbiter: RTL

//   Parametrised, registered priority encoder/arbiter for N request lines.

---
 rtl/priority_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter with a valid/ready output stage.
// Fixed priority (highest index wins) or round-robin, selected by RR_EN.
module priority_arbiter #(
  parameter int N     = 8,
  parameter int RR_EN = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  typedef enum logic {EMPTY, FULL} state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic [W-1:0]   ptrEff;
  logic [W-1:0]   winIdx;
  logic           found;
  logic           accept;
  logic           load;
  int             cand;

  assign accept = (state_q == FULL) && out_ready;
  assign load   = (state_q == EMPTY) || out_ready;

  // A same-cycle accept makes the just-granted index lowest priority for this search.
  assign ptrEff = ((RR_EN != 0) && accept) ? idx_q : ptr_q;

  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    cand   = 0;
    if (RR_EN == 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[W'(i)]) begin
          found  = 1'b1;
          winIdx = W'(i);
        end
      end
    end else begin
      // Walk the order from last to first so the earliest candidate overwrites the rest.
      for (int k = N; k >= 1; k--) begin
        cand = int'(ptrEff) + N - k;
        if (cand >= N) cand = cand - N;
        if (req[W'(cand)]) begin
          found  = 1'b1;
          winIdx = W'(cand);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    if ((RR_EN != 0) && accept) ptr_d = idx_q;
    if (load) begin
      if (found) begin
        state_d  = FULL;
        idx_d    = winIdx;
        onehot_d = ONE << winIdx;
      end else begin
        state_d  = EMPTY;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;

endmodule
